friscv_scfifo: RTL

// Single-clock FIFO: a write/read controller around a 2**ADDR_WIDTH-deep storage array.

---
 rtl/friscv_scfifo.sv | 83 ++++++++
 1 files changed

// File: rtl/friscv_scfifo.sv
// Single-clock valid/ready FIFO with a 2**ADDR_WIDTH-entry storage array.
// Wrap-flag pointers distinguish full from empty without a separate counter.
module friscv_scfifo #(
  parameter int ADDR_WIDTH   = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int AFULL_THRESH = 12
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  srst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  afull
);

  localparam int                DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] PTR_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] AFULL_LVL = AFULL_THRESH[ADDR_WIDTH:0];

  logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic full;
  logic empty;
  logic clear;
  logic push;
  logic pop;
  logic wr_en;

  // Same low bits with opposite wrap flags means the writer is one lap ahead.
  assign full  = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                 (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  assign in_ready  = ~full;
  assign out_valid = ~empty;

  assign clear = srst | flush;
  assign push  = in_valid & ~full;
  assign pop   = out_ready & ~empty;

  // A push coinciding with any reset or flush must not land in the array.
  assign wr_en = push & ~clear & aresetn;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is never reset; only the pointers define what is valid.
  always_ff @(posedge aclk) begin
    if (wr_en) mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= in_data;
  end

  assign out_data = mem[rd_ptr_q[ADDR_WIDTH-1:0]];
  assign count    = wr_ptr_q - rd_ptr_q;
  assign afull    = (count >= AFULL_LVL);

endmodule
